escalonador_clusters: RTL and testbench

Sequences lookups for the entry currently presented by the pending-request buffer. It walks that entry's cluster bitmap one cluster at a time in round-robin order and issues each lookup over a valid/ready handshake. It clears each cluster's bit as its response returns, writes the shrinking bitmap back to the buffer, and pulses `zero` to retire the entry on hit, exhaustion or empty bitmap. It sits between the buffer (upstream) and the cluster lookup fabric (downstream).

---
 rtl/escalonador_clusters_pkg.sv | 17 +
 rtl/escalonador_clusters_if.sv | 26 ++
 rtl/escalonador_clusters_arbitro_rr.sv | 32 +++
 rtl/escalonador_clusters.sv | 151 +++++++++++++++
 tb/tb_escalonador_clusters.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/escalonador_clusters_pkg.sv
// Shared types and default sizing for the cluster lookup scheduler.
package escalonador_pkg;

    localparam int NUM_CLUSTERS_DEF  = 5;
    localparam int TAM_ENDERECO_DEF  = 64;
    localparam int TAM_HASH_DOIS_DEF = 8;
    localparam int TEMPO_LIMITE_DEF  = 16;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SELECIONA = 3'd1,
        EMITE     = 3'd2,
        ESPERA    = 3'd3,
        RETIRA    = 3'd4
    } estado_t;

endpackage

// File: rtl/escalonador_clusters_if.sv
// Request/response channel between the scheduler and the cluster lookup fabric.
interface escalonador_clusters_if
    import escalonador_pkg::*;
#(
    parameter int NUM_CLUSTERS  = NUM_CLUSTERS_DEF,
    parameter int TAM_ENDERECO  = TAM_ENDERECO_DEF,
    parameter int TAM_HASH_DOIS = TAM_HASH_DOIS_DEF
);
    logic                     req_valido;
    logic                     req_pronto;
    logic [NUM_CLUSTERS-1:0]  req_cluster;
    logic [TAM_ENDERECO-1:0]  req_endereco;
    logic [TAM_HASH_DOIS-1:0] req_hash;
    logic                     resp_valida;
    logic                     resp_acerto;

    modport master (
        output req_valido, req_cluster, req_endereco, req_hash,
        input  req_pronto, resp_valida, resp_acerto
    );

    modport slave (
        input  req_valido, req_cluster, req_endereco, req_hash,
        output req_pronto, resp_valida, resp_acerto
    );
endinterface

// File: rtl/escalonador_clusters_arbitro_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module arbitro_rr #(
    parameter int  NUM_CLUSTERS = 5,
    localparam int PW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1
) (
    input  logic [NUM_CLUSTERS-1:0] req,
    input  logic [PW-1:0]           ptr,
    output logic [NUM_CLUSTERS-1:0] grant,
    output logic [PW-1:0]           idx
);
    int          j;
    logic        achou;
    logic [PW-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        achou = 1'b0;
        j     = 0;
        sel   = '0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CLUSTERS) j = j - NUM_CLUSTERS;
            sel = PW'(j);
            if (!achou && req[sel]) begin
                achou      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end
endmodule

// File: rtl/escalonador_clusters.sv
// Walks the presented entry's cluster bitmap, issuing one lookup at a time,
// and retires the entry on hit, exhaustion or an empty bitmap.
module escalonador_clusters
    import escalonador_pkg::*;
#(
    parameter int NUM_CLUSTERS  = NUM_CLUSTERS_DEF,
    parameter int TAM_ENDERECO  = TAM_ENDERECO_DEF,
    parameter int TAM_HASH_DOIS = TAM_HASH_DOIS_DEF,
    parameter int TEMPO_LIMITE  = TEMPO_LIMITE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     entrada_valida,
    input  logic [NUM_CLUSTERS-1:0]  bitmap_atual,
    input  logic [TAM_ENDERECO-1:0]  endereco_atual,
    input  logic [TAM_HASH_DOIS-1:0] hash_atual,
    output logic [NUM_CLUSTERS-1:0]  bitmap_atualizado,
    output logic                     zero,
    escalonador_clusters_if.master   fab,
    output logic                     resultado_valido,
    output logic                     resultado_acerto,
    output logic [NUM_CLUSTERS-1:0]  resultado_cluster,
    output logic                     resultado_erro,
    output logic                     ocupado
);
    localparam int PW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int CW = $clog2(TEMPO_LIMITE);

    estado_t                  estado_q, estado_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [NUM_CLUSTERS-1:0]  bitmap_q, bitmap_d;
    logic [TAM_ENDERECO-1:0]  endereco_q, endereco_d;
    logic [TAM_HASH_DOIS-1:0] hash_q, hash_d;
    logic [NUM_CLUSTERS-1:0]  cluster_q, cluster_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     erro_q, erro_d;
    logic                     acerto_q, acerto_d;
    logic [NUM_CLUSTERS-1:0]  res_cluster_q, res_cluster_d;

    logic [NUM_CLUSTERS-1:0]  grant;
    logic [PW-1:0]            grant_idx;
    logic [NUM_CLUSTERS-1:0]  bitmap_pos;
    logic                     expirou;
    logic                     retira;

    arbitro_rr #(.NUM_CLUSTERS(NUM_CLUSTERS)) u_arb (
        .req   (bitmap_q),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= OCIOSO;
            ptr_q         <= '0;
            bitmap_q      <= '0;
            endereco_q    <= '0;
            hash_q        <= '0;
            cluster_q     <= '0;
            cnt_q         <= '0;
            erro_q        <= 1'b0;
            acerto_q      <= 1'b0;
            res_cluster_q <= '0;
        end else begin
            estado_q      <= estado_d;
            ptr_q         <= ptr_d;
            bitmap_q      <= bitmap_d;
            endereco_q    <= endereco_d;
            hash_q        <= hash_d;
            cluster_q     <= cluster_d;
            cnt_q         <= cnt_d;
            erro_q        <= erro_d;
            acerto_q      <= acerto_d;
            res_cluster_q <= res_cluster_d;
        end
    end

    assign bitmap_pos = bitmap_q & ~cluster_q;
    assign expirou    = (cnt_q == CW'(TEMPO_LIMITE - 1));

    always_comb begin
        estado_d      = estado_q;
        ptr_d         = ptr_q;
        bitmap_d      = bitmap_q;
        endereco_d    = endereco_q;
        hash_d        = hash_q;
        cluster_d     = cluster_q;
        cnt_d         = cnt_q;
        erro_d        = erro_q;
        acerto_d      = acerto_q;
        res_cluster_d = res_cluster_q;
        case (estado_q)
            OCIOSO: if (entrada_valida) begin
                endereco_d    = endereco_atual;
                hash_d        = hash_atual;
                bitmap_d      = bitmap_atual;
                erro_d        = 1'b0;
                acerto_d      = 1'b0;
                res_cluster_d = '0;
                estado_d      = (bitmap_atual == '0) ? RETIRA : SELECIONA;
            end
            SELECIONA: begin
                cluster_d = grant;
                ptr_d     = (grant_idx == PW'(NUM_CLUSTERS - 1)) ? '0 : grant_idx + 1'b1;
                estado_d  = EMITE;
            end
            EMITE: if (fab.req_pronto) begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A response in the expiry cycle wins, so no error is flagged.
                if (fab.resp_valida || expirou) begin
                    bitmap_d = bitmap_pos;
                    if (!fab.resp_valida) erro_d = 1'b1;
                    if (fab.resp_valida && fab.resp_acerto) begin
                        acerto_d      = 1'b1;
                        res_cluster_d = cluster_q;
                        estado_d      = RETIRA;
                    end else if (bitmap_pos == '0) begin
                        estado_d = RETIRA;
                    end else begin
                        estado_d = SELECIONA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RETIRA:  estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    assign retira = (estado_q == RETIRA);

    always_comb begin
        fab.req_valido    = (estado_q == EMITE);
        fab.req_cluster   = cluster_q;
        fab.req_endereco  = endereco_q;
        fab.req_hash      = hash_q;
        // Outside OCIOSO the buffer must see our shrinking copy, not its stale one.
        bitmap_atualizado = (estado_q == OCIOSO) ? bitmap_atual : bitmap_q;
        zero              = retira;
        resultado_valido  = retira;
        resultado_acerto  = retira & acerto_q;
        resultado_cluster = retira ? res_cluster_q : '0;
        resultado_erro    = retira & erro_q;
        ocupado           = (estado_q != OCIOSO);
    end
endmodule

// File: tb/tb_escalonador_clusters.sv
// Directed bench for escalonador_clusters: one linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_escalonador_clusters;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        entrada_valida;
    logic [4:0]  bitmap_atual;
    logic [63:0] endereco_atual;
    logic [7:0]  hash_atual;
    logic [4:0]  bitmap_atualizado;
    logic        zero;
    logic        resultado_valido;
    logic        resultado_acerto;
    logic [4:0]  resultado_cluster;
    logic        resultado_erro;
    logic        ocupado;

    int tests = 0;
    int fails = 0;

    escalonador_clusters_if #(.NUM_CLUSTERS(5), .TAM_ENDERECO(64), .TAM_HASH_DOIS(8)) fab ();

    escalonador_clusters #(
        .NUM_CLUSTERS(5), .TAM_ENDERECO(64), .TAM_HASH_DOIS(8), .TEMPO_LIMITE(16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .entrada_valida    (entrada_valida),
        .bitmap_atual      (bitmap_atual),
        .endereco_atual    (endereco_atual),
        .hash_atual        (hash_atual),
        .bitmap_atualizado (bitmap_atualizado),
        .zero              (zero),
        .fab               (fab),
        .resultado_valido  (resultado_valido),
        .resultado_acerto  (resultado_acerto),
        .resultado_cluster (resultado_cluster),
        .resultado_erro    (resultado_erro),
        .ocupado           (ocupado)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_zero"},    64'(zero), 64'd0);
        check({tag, "_rv"},      64'(resultado_valido), 64'd0);
        check({tag, "_racerto"}, 64'(resultado_acerto), 64'd0);
        check({tag, "_rclus"},   64'(resultado_cluster), 64'd0);
        check({tag, "_rerro"},   64'(resultado_erro), 64'd0);
        check({tag, "_ocup"},    64'(ocupado), 64'd0);
        check({tag, "_reqv"},    64'(fab.req_valido), 64'd0);
        check({tag, "_reqc"},    64'(fab.req_cluster), 64'd0);
        check({tag, "_reqe"},    fab.req_endereco, 64'd0);
        check({tag, "_reqh"},    64'(fab.req_hash), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        entrada_valida = 1'b0;
        bitmap_atual = '0;
        endereco_atual = '0;
        hash_atual = '0;
        fab.req_pronto = 1'b0;
        fab.resp_valida = 1'b0;
        fab.resp_acerto = 1'b0;
        step();
        step();
        check_idle_outputs("rst");
        check("rst_bmp", 64'(bitmap_atualizado), 64'd0);
        rst_n = 1'b1;

        // Miss on every cluster of 10100 starting at ptr 0
        entrada_valida = 1'b1;
        bitmap_atual = 5'b10100;
        endereco_atual = 64'hDEAD_BEEF_0123_4567;
        hash_atual = 8'h5A;
        fab.req_pronto = 1'b1;
        #1 check("t1_passthru", 64'(bitmap_atualizado), 64'h14);
        step(); // SELECIONA
        check("t1_ocup", 64'(ocupado), 64'd1);
        check("t1_sel_reqv", 64'(fab.req_valido), 64'd0);
        step(); // EMITE
        check("t1_reqv", 64'(fab.req_valido), 64'd1);
        check("t1_grant0", 64'(fab.req_cluster), 64'h04);
        check("t1_end", fab.req_endereco, 64'hDEAD_BEEF_0123_4567);
        check("t1_hash", 64'(fab.req_hash), 64'h5A);
        step(); // ESPERA
        check("t1_esp_reqv", 64'(fab.req_valido), 64'd0);
        fab.resp_valida = 1'b1;
        fab.resp_acerto = 1'b0;
        step(); // SELECIONA
        check("t1_bmp1", 64'(bitmap_atualizado), 64'h10);
        check("t1_nozero", 64'(zero), 64'd0);
        fab.resp_valida = 1'b0;
        step(); // EMITE
        check("t1_grant1", 64'(fab.req_cluster), 64'h10);
        step(); // ESPERA
        fab.resp_valida = 1'b1;
        step(); // RETIRA
        check("t1_zero", 64'(zero), 64'd1);
        check("t1_rv", 64'(resultado_valido), 64'd1);
        check("t1_acerto", 64'(resultado_acerto), 64'd0);
        check("t1_rclus", 64'(resultado_cluster), 64'd0);
        check("t1_erro", 64'(resultado_erro), 64'd0);
        check("t1_bmp2", 64'(bitmap_atualizado), 64'd0);
        fab.resp_valida = 1'b0;
        entrada_valida = 1'b0;
        bitmap_atual = '0;
        step(); // OCIOSO
        check("t1_zero_pulse", 64'(zero), 64'd0);
        check("t1_idle", 64'(ocupado), 64'd0);

        // Hit on first cluster; grant 00001 also shows ptr wrapped back to 0
        entrada_valida = 1'b1;
        bitmap_atual = 5'b01011;
        endereco_atual = 64'h0000_0000_0000_1234;
        hash_atual = 8'hC3;
        step();
        step(); // EMITE
        check("t2_grant", 64'(fab.req_cluster), 64'h01);
        check("t2_hash", 64'(fab.req_hash), 64'hC3);
        step(); // ESPERA
        fab.resp_valida = 1'b1;
        fab.resp_acerto = 1'b1;
        step(); // RETIRA, 4 edges after accept
        check("t2_zero", 64'(zero), 64'd1);
        check("t2_acerto", 64'(resultado_acerto), 64'd1);
        check("t2_rclus", 64'(resultado_cluster), 64'h01);
        check("t2_bmp", 64'(bitmap_atualizado), 64'h0A);
        fab.resp_valida = 1'b0;
        fab.resp_acerto = 1'b0;
        entrada_valida = 1'b0;
        step();

        // Empty bitmap retires immediately as a miss
        entrada_valida = 1'b1;
        bitmap_atual = 5'b00000;
        step();
        check("t3_zero", 64'(zero), 64'd1);
        check("t3_acerto", 64'(resultado_acerto), 64'd0);
        check("t3_reqv", 64'(fab.req_valido), 64'd0);
        entrada_valida = 1'b0;
        step();
        check("t3_zero_pulse", 64'(zero), 64'd0);

        // Back-pressure, ptr now 1; a response during the handshake is ignored
        entrada_valida = 1'b1;
        bitmap_atual = 5'b00010;
        endereco_atual = 64'hAAAA_5555_AAAA_5555;
        fab.req_pronto = 1'b0;
        step();
        step(); // EMITE
        check("t4_reqv0", 64'(fab.req_valido), 64'd1);
        check("t4_clus0", 64'(fab.req_cluster), 64'h02);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_reqv_hold", 64'(fab.req_valido), 64'd1);
            check("t4_clus_hold", 64'(fab.req_cluster), 64'h02);
            check("t4_end_hold", fab.req_endereco, 64'hAAAA_5555_AAAA_5555);
        end
        fab.req_pronto = 1'b1;
        fab.resp_valida = 1'b1;
        fab.resp_acerto = 1'b1;
        step(); // ESPERA
        check("t4_hs_reqv", 64'(fab.req_valido), 64'd0);
        check("t4_hs_zero", 64'(zero), 64'd0);
        fab.resp_valida = 1'b0;
        step(); // still ESPERA
        check("t4_wait_zero", 64'(zero), 64'd0);
        check("t4_wait_ocup", 64'(ocupado), 64'd1);
        fab.resp_valida = 1'b1;
        step(); // RETIRA
        check("t4_zero", 64'(zero), 64'd1);
        check("t4_rclus", 64'(resultado_cluster), 64'h02);
        check("t4_bmp", 64'(bitmap_atualizado), 64'd0);
        fab.resp_valida = 1'b0;
        fab.resp_acerto = 1'b0;
        entrada_valida = 1'b0;
        step();

        // Timeout with ptr 2: grant wraps around to bit 1
        entrada_valida = 1'b1;
        bitmap_atual = 5'b00010;
        step();
        step(); // EMITE
        check("t5_grant", 64'(fab.req_cluster), 64'h02);
        step(); // ESPERA cycle 1
        repeat (15) step();
        check("t5_pre_zero", 64'(zero), 64'd0);
        check("t5_pre_ocup", 64'(ocupado), 64'd1);
        step(); // 16th ESPERA cycle expired
        check("t5_zero", 64'(zero), 64'd1);
        check("t5_erro", 64'(resultado_erro), 64'd1);
        check("t5_acerto", 64'(resultado_acerto), 64'd0);
        check("t5_bmp", 64'(bitmap_atualizado), 64'd0);
        entrada_valida = 1'b0;
        step();

        // Response on the expiry cycle beats the timeout
        entrada_valida = 1'b1;
        step();
        step();
        step(); // ESPERA cycle 1
        repeat (15) step();
        fab.resp_valida = 1'b1;
        fab.resp_acerto = 1'b0;
        step();
        check("t5b_zero", 64'(zero), 64'd1);
        check("t5b_erro", 64'(resultado_erro), 64'd0);
        fab.resp_valida = 1'b0;
        entrada_valida = 1'b0;
        step();

        // Reset during ESPERA with ptr 2 -> 3; afterwards grant must come from ptr 0
        entrada_valida = 1'b1;
        bitmap_atual = 5'b10100;
        endereco_atual = 64'h1111_2222_3333_4444;
        step();
        step();
        check("t6_grant", 64'(fab.req_cluster), 64'h04);
        step(); // ESPERA
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("t6_rst");
        check("t6_rst_bmp", 64'(bitmap_atualizado), 64'h14);
        step();
        check("t6_rst_nozero", 64'(zero), 64'd0);
        rst_n = 1'b1;
        step(); // SELECIONA
        step(); // EMITE
        check("t6_ptr0_grant", 64'(fab.req_cluster), 64'h04);
        step(); // ESPERA
        fab.resp_valida = 1'b1;
        fab.resp_acerto = 1'b1;
        step();
        check("t6_zero", 64'(zero), 64'd1);
        check("t6_rclus", 64'(resultado_cluster), 64'h04);
        check("t6_bmp", 64'(bitmap_atualizado), 64'h10);
        fab.resp_valida = 1'b0;
        fab.resp_acerto = 1'b0;
        entrada_valida = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
